// File: rtl/am_sqrt_scheduler.sv
// am_sqrt_scheduler: round-robin sharing of one iterative sqrt core between NUM_CH I/Q channels.
// Forms P = I*I + Q*Q, launches the core, returns floor(sqrt(P)) tagged with its channel.
module am_sqrt_scheduler #(
    parameter int IQ_W    = 12,
    parameter int N       = 24,
    parameter int NUM_CH  = 2,
    parameter int CH_W    = 1,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [NUM_CH-1:0]      in_valid_i,
    output logic [NUM_CH-1:0]      in_ready_o,
    input  logic [NUM_CH*IQ_W-1:0] in_i_i,
    input  logic [NUM_CH*IQ_W-1:0] in_q_i,
    output logic                   core_start_o,
    output logic [N-1:0]           core_num_o,
    input  logic                   core_done_i,
    input  logic [N/2-1:0]         core_root_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [N/2-1:0]         out_mag_o,
    output logic [CH_W-1:0]        out_ch_o,
    output logic                   err_o
);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {S_IDLE, S_SQ, S_LAUNCH, S_WAIT, S_HOLD} state_t;
    state_t state_q, state_d;
    logic [CH_W-1:0] rr_q, tag_q, och_q, gnt, c;
    logic signed [IQ_W-1:0] i_q, q_q;
    logic signed [IQ_W-1:0] smp_i [NUM_CH];
    logic signed [IQ_W-1:0] smp_q [NUM_CH];
    logic signed [N-1:0] sq_i, sq_q;
    logic [N-1:0] p_q;
    logic [TW-1:0] cnt_q;
    logic [N/2-1:0] mag_q;
    logic err_q, take, tmo;
    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign smp_i[g] = in_i_i[g*IQ_W +: IQ_W];
        assign smp_q[g] = in_q_i[g*IQ_W +: IQ_W];
    end
    // Descending scan so the channel nearest the rr pointer is assigned last and wins.
    always_comb begin
        gnt = '0;
        c = '0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            c = CH_W'((int'(rr_q) + j) % NUM_CH);
            if (in_valid_i[c]) gnt = c;
        end
    end
    assign take = (state_q == S_IDLE) && (|in_valid_i);
    assign tmo  = cnt_q == TW'(TIMEOUT - 1);
    assign sq_i = N'(i_q) * N'(i_q);
    assign sq_q = N'(q_q) * N'(q_q);
    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= S_IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = take ? S_SQ : S_IDLE;
            S_SQ:     state_d = S_LAUNCH;
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT:   state_d = core_done_i ? S_HOLD : (tmo ? S_IDLE : S_WAIT);
            S_HOLD:   state_d = out_ready_i ? S_IDLE : S_HOLD;
            default:  state_d = S_IDLE;
        endcase
    end
    always_comb begin
        in_ready_o   = (take && !reset_i) ? (NUM_CH'(1) << gnt) : '0;
        core_start_o = state_q == S_LAUNCH;
        out_valid_o  = state_q == S_HOLD;
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_q  <= '0;
            tag_q <= '0;
            i_q   <= '0;
            q_q   <= '0;
            p_q   <= '0;
            cnt_q <= '0;
            mag_q <= '0;
            och_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (take) begin
                rr_q  <= CH_W'((int'(gnt) + 1) % NUM_CH);
                tag_q <= gnt;
                i_q   <= smp_i[gnt];
                q_q   <= smp_q[gnt];
            end
            if (state_q == S_SQ) p_q <= $unsigned(sq_i) + $unsigned(sq_q);
            cnt_q <= (state_q == S_WAIT) ? cnt_q + TW'(1) : '0;
            if (state_q == S_WAIT && core_done_i) begin
                mag_q <= core_root_i;
                och_q <= tag_q;
            end
            if (state_q == S_WAIT && !core_done_i && tmo) err_q <= 1'b1;
        end
    end
    assign core_num_o = p_q;
    assign out_mag_o  = mag_q;
    assign out_ch_o   = och_q;
    assign err_o      = err_q;
endmodule
